// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/mret CSR sequencer issuing one PC redirect per request; mstatus update under TRAP_MSTATUS_EN
module trap_ctrl #(
  parameter logic [31:0] CAUSE_ECALL   = 32'd11,
  parameter logic [31:0] CAUSE_EBREAK  = 32'd3,
  parameter logic [31:0] CAUSE_ILLEGAL = 32'd2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [31:0] req_pc,
  output logic [11:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic [11:0] csr_waddr1,
  output logic [31:0] csr_wdata1,
  output logic        csr_wen1,
  output logic [11:0] csr_waddr2,
  output logic [31:0] csr_wdata2,
  output logic        csr_wen2,
  output logic        pc_wen,
  output logic [31:0] pc_wdata,
  output logic        stall,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, REDIR, SRD, SWR} state_t;
`ifdef TRAP_MSTATUS_EN
  localparam state_t POST = SRD;
`else
  localparam state_t POST = REDIR;
`endif
  state_t state, nxt;
  logic [1:0] typ;
  logic [31:0] pc, target, cause;
  logic mret;
  assign mret = typ == 2'b01;
  assign cause = typ == 2'b00 ? CAUSE_ECALL : typ == 2'b10 ? CAUSE_EBREAK : CAUSE_ILLEGAL;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state  <= IDLE;
      typ    <= 2'b00;
      pc     <= 32'd0;
      target <= 32'd0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        typ <= req_type;
        pc  <= req_pc;
      end
      if (state == READ) target <= csr_rdata & ~32'd3;
    end
  always_comb begin
    nxt = state == IDLE  ? (req_valid ? READ : IDLE) :
          state == READ  ? (mret ? POST : WRITE) :
          state == WRITE ? POST :
          state == SRD   ? SWR :
          state == SWR   ? REDIR : IDLE;
  end
  assign req_ready  = state == IDLE;
  assign stall      = state != IDLE;
  assign done       = state == REDIR;
  assign pc_wen     = state == REDIR;
  assign pc_wdata   = state == REDIR ? target : 32'd0;
  assign csr_wen2   = state == WRITE;
  assign csr_waddr2 = state == WRITE ? 12'h342 : 12'h000;
  assign csr_wdata2 = state == WRITE ? cause : 32'd0;
`ifdef TRAP_MSTATUS_EN
  logic [31:0] status, sw;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) status <= 32'd0;
    else if (state == SRD) status <= csr_rdata;
  assign sw = mret ? {status[31:13], 2'b11, status[10:8], 1'b1, status[6:4], status[7], status[2:0]}
                   : {status[31:13], 2'b11, status[10:8], status[3], status[6:4], 1'b0, status[2:0]};
  assign csr_raddr  = state == READ ? (mret ? 12'h341 : 12'h305) : state == SRD ? 12'h300 : 12'h000;
  assign csr_wen1   = state == WRITE || state == SWR;
  assign csr_waddr1 = state == WRITE ? 12'h341 : state == SWR ? 12'h300 : 12'h000;
  assign csr_wdata1 = state == WRITE ? pc : state == SWR ? sw : 32'd0;
`else
  assign csr_raddr  = state == READ ? (mret ? 12'h341 : 12'h305) : 12'h000;
  assign csr_wen1   = state == WRITE;
  assign csr_waddr1 = state == WRITE ? 12'h341 : 12'h000;
  assign csr_wdata1 = state == WRITE ? pc : 32'd0;
`endif
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: randomized and directed check of trap_ctrl against a per-transaction cycle model
module tb_trap_ctrl;
  typedef struct packed {
    logic        ready;
    logic        stall;
    logic        done;
    logic        pc_wen;
    logic [31:0] pc_wdata;
    logic [11:0] raddr;
    logic        wen1;
    logic [11:0] waddr1;
    logic [31:0] wdata1;
    logic        wen2;
    logic [11:0] waddr2;
    logic [31:0] wdata2;
  } obs_t;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0, req_valid = 1'b0;
  logic [1:0] req_type = 2'b00;
  logic [31:0] req_pc = 32'd0;
  logic req_ready, csr_wen1, csr_wen2, pc_wen, stall, done;
  logic [11:0] csr_raddr, csr_waddr1, csr_waddr2;
  logic [31:0] csr_rdata, csr_wdata1, csr_wdata2, pc_wdata;
  logic [31:0] mtvec = 32'd0, mepc = 32'd0, mstatus = 32'd0;
  obs_t obs;
  int n_cmp = 0, n_err = 0;
  trap_ctrl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_pc(req_pc), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr1(csr_waddr1), .csr_wdata1(csr_wdata1), .csr_wen1(csr_wen1),
    .csr_waddr2(csr_waddr2), .csr_wdata2(csr_wdata2), .csr_wen2(csr_wen2),
    .pc_wen(pc_wen), .pc_wdata(pc_wdata), .stall(stall), .done(done)
  );
  always #5 sys_clk = ~sys_clk;
  always_comb csr_rdata = csr_raddr == 12'h305 ? mtvec : csr_raddr == 12'h341 ? mepc :
                          csr_raddr == 12'h300 ? mstatus : 32'hDEAD_BEEF;
  assign obs = {req_ready, stall, done, pc_wen, pc_wdata, csr_raddr, csr_wen1, csr_waddr1, csr_wdata1,
                csr_wen2, csr_waddr2, csr_wdata2};
  function automatic obs_t idle_o();
    obs_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction
  function automatic logic [31:0] cause_of(input logic [1:0] t);
    return t == 2'b00 ? 32'd11 : t == 2'b10 ? 32'd3 : 32'd2;
  endfunction
  function automatic logic [31:0] new_status(input logic [1:0] t, input logic [31:0] st);
    logic [31:0] s = st;
    if (t == 2'b01) begin
      s[3] = st[7];
      s[7] = 1'b1;
    end else begin
      s[7] = st[3];
      s[3] = 1'b0;
    end
    s[12:11] = 2'b11;
    return s;
  endfunction
  task automatic chk(input string tag, input obs_t e);
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic run_txn(input logic [1:0] t, input logic [31:0] p, input logic hold, input string tag);
    obs_t q[$];
    obs_t o;
    req_valid = 1'b1;
    req_type  = t;
    req_pc    = p;
    chk({tag, "/idle"}, idle_o());
    tick();
    if (!hold) req_valid = 1'b0;
    o = '0; o.stall = 1'b1; o.raddr = t == 2'b01 ? 12'h341 : 12'h305;
    q.push_back(o);
    if (t != 2'b01) begin
      o = '0; o.stall = 1'b1;
      o.wen1 = 1'b1; o.waddr1 = 12'h341; o.wdata1 = p;
      o.wen2 = 1'b1; o.waddr2 = 12'h342; o.wdata2 = cause_of(t);
      q.push_back(o);
    end
`ifdef TRAP_MSTATUS_EN
    o = '0; o.stall = 1'b1; o.raddr = 12'h300;
    q.push_back(o);
    o = '0; o.stall = 1'b1; o.wen1 = 1'b1; o.waddr1 = 12'h300; o.wdata1 = new_status(t, mstatus);
    q.push_back(o);
`endif
    o = '0; o.stall = 1'b1; o.done = 1'b1; o.pc_wen = 1'b1;
    o.pc_wdata = (t == 2'b01 ? mepc : mtvec) & ~32'd3;
    q.push_back(o);
    foreach (q[i]) begin
      chk($sformatf("%s/c%0d", tag, i + 1), q[i]);
      tick();
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge sys_clk);
    #1;
    chk("reset_hold", idle_o());
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();
    chk("reset_release", idle_o());
    mtvec = 32'h8000_1003;
    run_txn(2'b00, 32'h8000_0010, 1'b0, "ecall");
    mepc = 32'h8000_0014;
    run_txn(2'b01, 32'h8000_0040, 1'b0, "mret");
    mtvec = 32'h0000_0200;
    run_txn(2'b10, 32'h0000_1234, 1'b1, "ebreak_busy");
    run_txn(2'b10, 32'h0000_1234, 1'b0, "ebreak_b2b");
    chk("after_b2b", idle_o());
    req_valid = 1'b1;
    req_type  = 2'b00;
    req_pc    = 32'h0000_0100;
    tick();
    req_valid = 1'b0;
    tick();
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_drop", idle_o());
    tick();
    chk("async_rst_hold", idle_o());
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();
    chk("async_rst_rel1", idle_o());
    tick();
    chk("async_rst_rel2", idle_o());
`ifdef TRAP_MSTATUS_EN
    mtvec   = 32'h0000_0300;
    mstatus = 32'h0000_1808;
    run_txn(2'b11, 32'h0000_0444, 1'b0, "illegal_ms");
    mstatus = 32'h0000_1880;
    mepc    = 32'h0000_0448;
    run_txn(2'b01, 32'h0000_0000, 1'b0, "mret_ms");
`endif
    for (int i = 0; i < 40; i++) begin
      mtvec   = $urandom;
      mepc    = $urandom;
      mstatus = $urandom;
      run_txn(2'($urandom_range(0, 3)), $urandom, 1'b0, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) begin
        chk($sformatf("rand%0d/gap", i), idle_o());
        tick();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Multi-cycle trap/return sequencer sitting between decode and the writeback/register-file unit.
- Accepts one ecall/ebreak/illegal/mret request at a time over a valid/ready handshake.
- Sequences CSR reads (mtvec/mepc) and CSR writes (mepc, mcause, optionally mstatus) over the register-file unit's single CSR read port and dual CSR write ports, then issues exactly one PC redirect.
- Holds the front end stalled for the whole sequence.

Parameters:
- CAUSE_ECALL, 32'd11, mcause value for ecall (M-mode).
- CAUSE_EBREAK, 32'd3, mcause value for ebreak.
- CAUSE_ILLEGAL, 32'd2, mcause value for illegal instruction.

Ports:
- sys_clk  in  1  clock, all state on rising edge.
- sys_rst_n  in  1  async reset, active-low.
- req_valid  in  1  trap/return request.
- req_ready  out  1  controller idle, request accepted when valid&ready.
- req_type  in  2  00 ecall, 01 mret, 10 ebreak, 11 illegal.
- req_pc  in  32  PC of the trapping instruction.
- csr_raddr  out  12  CSR read address.
- csr_rdata  in  32  CSR read data (combinational from regfile).
- csr_waddr1  out  12  CSR write port 1 address.
- csr_wdata1  out  32  CSR write port 1 data.
- csr_wen1  out  1  CSR write port 1 enable.
- csr_waddr2  out  12  CSR write port 2 address.
- csr_wdata2  out  32  CSR write port 2 data.
- csr_wen2  out  1  CSR write port 2 enable; only ever asserted together with csr_wen1.
- pc_wen  out  1  PC redirect strobe.
- pc_wdata  out  32  redirect target.
- stall  out  1  hold fetch/issue.
- done  out  1  one-cycle completion pulse.

Behaviour:
- **Reset.** sys_rst_n low forces IDLE asynchronously. All internal registers (type, pc, target, status) clear to 0.
- **Outputs decoded from state only (Moore).** Reset values: req_ready=1, stall=0, done=0, all wen/pc_wen=0, all addr/data=0.
- **States:** IDLE, READ, WRITE, REDIR (plus SRD, SWR with the feature).
- **IDLE**
  - req_ready=1, stall=0.
  - On req_valid: latch req_type and req_pc → READ.
- **READ**
  - csr_raddr = 0x305 (ecall/ebreak/illegal) or 0x341 (mret).
  - Capture target = {csr_rdata[31:2], 2'b00} at the clock edge.
  - Trap → WRITE.
  - mret → REDIR (→ SRD with the feature).
- **WRITE**
  - wen1=1, waddr1=0x341, wdata1=latched pc.
  - wen2=1, waddr2=0x342, wdata2=cause selected by type.
  - Next state → REDIR (→ SRD with the feature).
- **REDIR**
  - pc_wen=1, pc_wdata=target, done=1.
  - Next state → IDLE.
- **stall** = (state != IDLE).
- **req_ready** = (state == IDLE). Requests while busy are not accepted; the requester holds valid and stable.
- **Latency** from accept edge to pc_wen cycle (feature off): trap 3 cycles, mret 2 cycles.
- **Back-to-back:** a new request is acceptable in the cycle after REDIR (IDLE). Minimum spacing is 4 cycles (trap) / 3 cycles (mret).
- **mtvec:** treated as direct mode; low 2 bits always masked.
- **Reset mid-sequence:** outputs drop in the same cycle. No partial CSR write beyond those already clocked; no pc_wen.
- **Unknown state encodings:** recover to IDLE.

Optional Feature:
- Macro: TRAP_MSTATUS_EN.
- **Defined:** after WRITE (trap) or READ (mret), FSM visits SRD then SWR before REDIR.
  - SRD: csr_raddr=0x300; capture status.
  - SWR: wen1=1, waddr1=0x300, wen2=0.
    - Trap: wdata1 = status with bit7 (MPIE) := bit3 (MIE), bit3 := 0, bits[12:11] := 2'b11.
    - mret: bit3 := bit7, bit7 := 1, bits[12:11] := 2'b11.
  - Latency becomes trap 5, mret 4.
- **Undefined:** SRD/SWR absent; mstatus never written.

Test Plan:
1. **Reset values.** Reset low then release → req_ready=1, stall=0, all wen/pc_wen/done=0, addresses 0.
2. **Ecall.** Ecall with req_pc=0x80000010, mtvec reads 0x80001003:
   - READ cycle: raddr=0x305.
   - Next cycle: wen1/wen2 with (0x341, 0x80000010) and (0x342, 11).
   - Next cycle: pc_wen=1, pc_wdata=0x80001000, done=1.
3. **mret.** mret with mepc reads 0x80000014 → raddr=0x341, then pc_wen with 0x80000014 two cycles after accept; no CSR write (feature off).
4. **Busy/back-to-back.**
   - req_valid held high during an ebreak sequence → req_ready=0 and stall=1 for 3 cycles.
   - Second request accepted on the IDLE cycle.
   - mcause=3 written on the first sequence.
5. **Async reset.** Assert sys_rst_n low during WRITE (between edges) → wen1/wen2 drop immediately; IDLE after release; no pc_wen.
6. **TRAP_MSTATUS_EN.**
   - Illegal trap with mstatus=0x00001808 → SWR writes 0x00001880, cause 2.
   - Following mret with mstatus=0x00001880 → writes 0x00001888.
